// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared constants, types and the 5x7 glyph table for the
//               LED matrix column scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam int COL_W  = 3;

  // Functionality code delivered by the matrix-path selector
  typedef logic [2:0] code_t;

  // GLYPH_TABLE[code][column] is the row pattern for that column, bit 0 = top.
  // Entries are listed from code 7 down to code 0, column 4 down to column 0.
  // Code 0 is the "access denied" X; code 7 is an all-dark glyph.
  localparam logic [7:0][N_COLS-1:0][N_ROWS-1:0] GLYPH_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // code 7
    7'h30, 7'h49, 7'h49, 7'h4A, 7'h3C,  // code 6
    7'h39, 7'h45, 7'h45, 7'h45, 7'h27,  // code 5
    7'h10, 7'h7F, 7'h12, 7'h14, 7'h18,  // code 4
    7'h36, 7'h49, 7'h49, 7'h41, 7'h22,  // code 3
    7'h46, 7'h49, 7'h49, 7'h51, 7'h62,  // code 2
    7'h00, 7'h40, 7'h7F, 7'h42, 7'h00,  // code 1
    7'h41, 7'h22, 7'h1C, 7'h22, 7'h41   // code 0
  };

  // Active-low one-cold column enable for a column index
  function automatic logic [N_COLS-1:0] col_enable_n(input logic [COL_W-1:0] idx);
    return ~(N_COLS'(1) << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : matrix_glyph_rom
// Description : Combinational lookup of the row pattern for one column of
//               the glyph selected by a functionality code.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_glyph_rom
  import matrix_pkg::*;
(
  input  code_t                   code,
  input  logic [COL_W-1:0]        col,
  output logic [N_ROWS-1:0]       pattern
);

  // Table lookup; column indices beyond the matrix read as dark
  always_comb begin
    pattern = '0;
    if (col < COL_W'(N_COLS)) begin
      pattern = GLYPH_TABLE[code][col];
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scan
// Description : 5x7 LED matrix column scanner. A prescaler divides clk into
//               column slots, the column index walks 0..4, and the displayed
//               code is swapped only at frame boundaries. Each slot begins
//               with BLANK dead-time cycles to avoid ghosting.
//               Optional macro MATRIX_BLINK_EN: blink code 0 with a period of
//               2*BLINK_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan
  import matrix_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        code_in,
  input  logic              load,
  output logic [N_COLS-1:0] col_n,
  output logic [N_ROWS-1:0] row,
  output logic              frame_done
);

  localparam int                PW       = $clog2(DIV);
  localparam logic [PW-1:0]     PS_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0]     PS_BLANK = PW'(BLANK);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);

  logic              r_started;
  logic [PW-1:0]     r_presc;
  logic [COL_W-1:0]  r_index;
  code_t             r_active;
  code_t             r_pending;
  logic              r_flag;

  logic              w_tick;
  logic              w_frame_tick;
  logic [COL_W-1:0]  w_next_index;
  code_t             w_active_next;
  logic [N_ROWS-1:0] w_pattern;
  logic              w_blink_mute;

  assign w_tick       = r_started && (r_presc == PS_LAST);
  assign w_frame_tick = w_tick && (r_index == COL_LAST);
  assign w_next_index = (r_index == COL_LAST) ? '0 : r_index + COL_W'(1);

  // Prescaler; the first edge after reset only arms the scan so column 0
  // gets a full slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      r_presc   <= '0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else if (w_tick) begin
      r_presc   <= '0;
    end else begin
      r_presc   <= r_presc + PW'(1);
    end
  end

  // Column index and registered column enables move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
      col_n   <= '1;
    end else if (!r_started) begin
      col_n   <= col_enable_n('0);
    end else if (w_tick) begin
      r_index <= w_next_index;
      col_n   <= col_enable_n(w_next_index);
    end
  end

  // Frame-complete pulse, registered on the 4->0 tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_tick;
    end
  end

  // Next displayed code: a load on the frame tick wins over the pending one
  always_comb begin
    w_active_next = r_active;
    if (w_frame_tick) begin
      if (load) begin
        w_active_next = code_in;
      end else if (r_flag) begin
        w_active_next = r_pending;
      end
    end
  end

  // Code registers; pending is consumed or bypassed only at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_pending <= '0;
      r_flag    <= 1'b0;
    end else begin
      r_active <= w_active_next;
      if (w_frame_tick) begin
        r_flag <= 1'b0;
      end else if (load) begin
        r_pending <= code_in;
        r_flag    <= 1'b1;
      end
    end
  end

`ifdef MATRIX_BLINK_EN
  localparam int               BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;

  // Frame counter toggling the blink phase while code 0 is shown; a code
  // change restarts the cycle in the on phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_tick) begin
      if (w_active_next != r_active) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_active == code_t'(0)) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign w_blink_mute = (r_active == code_t'(0)) && !r_blink_on;
`else
  logic w_unused_blink_cfg;
  assign w_unused_blink_cfg = |BLINK_FRAMES;
  assign w_blink_mute       = 1'b0;
`endif

  matrix_glyph_rom u_glyph_rom (
    .code    (r_active),
    .col     (r_index),
    .pattern (w_pattern)
  );

  // Row drive is gated by r_started so reset darkens it without a clock
  assign row = (r_started && (r_presc >= PS_BLANK) && !w_blink_mute) ? w_pattern : '0;

endmodule
`default_nettype wire
